// File: rtl/phase_ramp_pkg.sv
// Shared DSP types and constants for the phase ramp and the downstream rotate stage.
// Phase arguments use the full two's-complement range: PI is the most negative value.
package phase_ramp_pkg;

  localparam int unsigned AMP_W = 16;
  localparam int unsigned ARG_W = 2 * AMP_W;

  typedef logic signed [AMP_W-1:0] amp_t;
  typedef logic signed [ARG_W-1:0] arg_t;

  localparam arg_t PI   = {1'b1, {(ARG_W-1){1'b0}}};
  localparam arg_t PI_2 = {2'b01, {(ARG_W-2){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/skid_buffer.sv
// Output register plus one-entry skid buffer; s_ready comes straight from a flop,
// so it never depends combinationally on m_ready.
module skid_buffer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              s_ready_q, s_ready_d;
  logic              accept;

  assign accept = s_valid && s_ready_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    if (!out_valid_q || m_ready) begin
      // s_ready_q is low whenever the skid is full, so accept cannot coincide with a drain
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        skid_full_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = s_data;
        end
      end
    end else if (accept) begin
      skid_full_d = 1'b1;
      skid_data_d = s_data;
    end
    s_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      s_ready_q   <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      s_ready_q   <= s_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  assign s_ready = s_ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/phase_ramp.sv
// Tags each sample of a packet with phase k*inc (mod 2^(2*WIDTH)); the increment
// is latched between packets so it stays fixed for a whole packet.
module phase_ramp
  import phase_ramp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*WIDTH-1:0] s_data,
  input  logic               s_last,
  input  logic               freq_valid,
  input  logic [2*WIDTH-1:0] freq_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [4*WIDTH-1:0] m_data,
  output logic               m_last
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned DW = 4 * WIDTH + 1;

  ramp_state_t   state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] active_q, active_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          accept;
  logic [DW-1:0] sk_in, sk_out;

  assign accept = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    active_d  = active_q;
    pending_d = freq_valid ? freq_data : pending_q;
    if (accept) begin
      if (s_last) begin
        acc_d   = '0;
        state_d = ST_IDLE;
      end else begin
        acc_d   = acc_q + active_q;
        state_d = ST_BUSY;
      end
    end else if (state_q == ST_IDLE) begin
      // only between packets, so a load landing on a first sample waits for the next packet
      active_d = pending_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign sk_in = {s_last, acc_q, s_data};

  skid_buffer #(
    .DATA_W(DW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (sk_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (sk_out)
  );

  assign m_last = sk_out[DW-1];
  assign m_data = sk_out[DW-2:0];

endmodule

// File: tb/tb_phase_ramp.sv
// Scoreboard bench for phase_ramp: the driver queues {last, phase, q, i} on acceptance,
// the monitor pops and compares on every output transfer.
module tb_phase_ramp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        freq_valid = 1'b0;
  logic [31:0] freq_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        m_last;

  int compared = 0;
  int mismatched = 0;
  logic [64:0] sb_q[$];
  int          held = 0;
  bit          stall_prev = 1'b0;
  logic [64:0] stall_val;
  int          rdy_mode = 0;

  logic [31:0] t1_ph [10] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000,
                              32'h8000_0000, 32'hA000_0000, 32'hC000_0000, 32'hE000_0000,
                              32'h0000_0000, 32'h2000_0000};

  always #5 clk = ~clk;

  phase_ramp #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .freq_valid (freq_valid),
    .freq_data  (freq_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // m_ready driver: mode 1 repeats 1,0,0,1
  initial begin
    int p = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        m_ready = ((p % 4) == 0) || ((p % 4) == 3);
        p++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // held tracks samples inside the DUT after the last edge: 0, 1 (output reg) or 2 (plus skid)
  always @(negedge clk) begin
    logic [64:0] exp;
    if (!reset) begin
      check("s_ready_vs_occupancy", 128'(s_ready), 128'(held != 2));
      check("m_valid_vs_occupancy", 128'(m_valid), 128'(held != 0));
      if (stall_prev)
        check("stall_hold", {m_valid, m_last, m_data}, {1'b1, stall_val});
      stall_prev = m_valid && !m_ready;
      stall_val  = {m_last, m_data};
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got %h expected no output", {m_last, m_data});
        end else begin
          exp = sb_q.pop_front();
          check("out_data", {m_last, m_data}, exp);
        end
      end
      held += int'(s_valid && s_ready) - int'(m_valid && m_ready);
    end
  end

  task automatic send(input logic [15:0] i, input logic [15:0] q, input bit last,
                      input logic [31:0] ph, input bit fv = 1'b0, input logic [31:0] fd = '0);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = {q, i};
    s_last  = last;
    if (fv) begin
      freq_valid = 1'b1;
      freq_data  = fd;
    end
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      sb_q.push_back({last, ph, q, i});
      @(posedge clk);
      #1;
    end else begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got s_ready=0 for 50 cycles expected acceptance");
    end
    s_valid    = 1'b0;
    freq_valid = 1'b0;
  endtask

  task automatic load_freq(input logic [31:0] v);
    freq_valid = 1'b1;
    freq_data  = v;
    @(posedge clk);
    #1;
    freq_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (sb_q.size() == 0 && held == 0) break;
    end
    #1;
    check("drain_empty", 128'(sb_q.size()), 128'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", 128'(m_valid), 128'(0));
    check("reset_s_ready", 128'(s_ready), 128'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 10-sample packet, inc = pi/4
    load_freq(32'h2000_0000);
    for (int k = 0; k < 10; k++)
      send(16'(k * 16'h0111 + 1), 16'(16'h8000 - k), k == 9, t1_ph[k]);
    drain();

    // negative increment -pi/8
    load_freq(32'hF000_0000);
    send(16'h1234, 16'hFEDC, 1'b0, 32'h0000_0000);
    send(16'h7FFF, 16'h8000, 1'b0, 32'hF000_0000);
    send(16'h0001, 16'hFFFF, 1'b1, 32'hE000_0000);
    drain();

    // increment change mid-packet applies only to the next packet
    load_freq(32'h2000_0000);
    send(16'h0010, 16'h0020, 1'b0, 32'h0000_0000);
    send(16'h0011, 16'h0021, 1'b0, 32'h2000_0000, 1'b1, 32'h1000_0000);
    send(16'h0012, 16'h0022, 1'b0, 32'h4000_0000);
    send(16'h0013, 16'h0023, 1'b1, 32'h6000_0000);
    drain();
    send(16'h0030, 16'h0040, 1'b0, 32'h0000_0000, 1'b1, 32'h3000_0000);
    send(16'h0031, 16'h0041, 1'b0, 32'h1000_0000);
    send(16'h0032, 16'h0042, 1'b1, 32'h2000_0000);
    drain();
    send(16'h0050, 16'h0060, 1'b0, 32'h0000_0000);
    send(16'h0051, 16'h0061, 1'b1, 32'h3000_0000);
    drain();

    // 100 samples under m_ready 1,0,0,1 back-pressure
    load_freq(32'h0001_0000);
    rdy_mode = 1;
    for (int k = 0; k < 100; k++)
      send(16'(k), 16'(~k), k == 99, {16'(k), 16'h0000});
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // asynchronous reset after 4 of 8 samples
    for (int k = 0; k < 4; k++)
      send(16'(k + 100), 16'(k + 200), 1'b0, {16'(k), 16'h0000});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_m_valid", 128'(m_valid), 128'(0));
    sb_q.delete();
    held = 0;
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(16'h0AAA, 16'h0BBB, 1'b0, 32'h0000_0000);
    send(16'h0AAB, 16'h0BBC, 1'b0, 32'h0000_0000);
    send(16'h0AAC, 16'h0BBD, 1'b1, 32'h0000_0000);
    drain();

    // back-to-back single-sample packets
    load_freq(32'h2000_0000);
    for (int k = 0; k < 8; k++)
      send(16'(k + 16'h0C00), 16'(k + 16'h0D00), 1'b1, 32'h0000_0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/phase_ramp.md
PHASE_RAMP -- requirements
Module: phase_ramp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample component width in bits; phase width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port s_valid  input  1  input sample valid.
REQ-005 SHALL have port s_ready  output  1  input sample accepted when s_valid && s_ready.
REQ-006 SHALL have port s_data  input  2*WIDTH  {q, i}, signed, i in low half.
REQ-007 SHALL have port s_last  input  1  final sample of packet.
REQ-008 SHALL have port freq_valid  input  1  load strobe for frequency increment.
REQ-009 SHALL have port freq_data  input  2*WIDTH  signed phase increment per sample; 2^(2*WIDTH-1) = pi.
REQ-010 SHALL have port m_valid  output  1  output valid.
REQ-011 SHALL have port m_ready  input  1  downstream ready.
REQ-012 SHALL have port m_data  output  4*WIDTH  {phase, q, i}; phase in top 2*WIDTH bits, q and i passed unchanged.
REQ-013 SHALL have port m_last  output  1  s_last of the same sample, delayed.

Function
REQ-014 SHALL tag each accepted sample k of a packet (k = 0 at first sample) with phase = k * inc modulo 2^(2*WIDTH), two's-complement wrap, no saturation.
REQ-015 SHALL use as inc the active increment register, fixed for the whole packet.
REQ-016 SHALL hold a 2-state FSM: IDLE (no packet in progress) and BUSY (at least one sample of the current packet accepted, last not yet accepted).
REQ-017 SHALL transition IDLE->BUSY on an accepted sample with s_last=0; BUSY->IDLE on an accepted sample with s_last=1; an accepted single-sample packet (s_last=1 in IDLE) keeps state IDLE.
REQ-018 SHALL capture freq_data into a pending register on freq_valid in any state; a later freq_valid overwrites an earlier unapplied one.
REQ-019 SHALL copy pending to active only while in IDLE and no sample is accepted that cycle; a freq_valid coinciding with acceptance of a packet's first sample applies to the following packet.
REQ-020 SHALL clear the phase accumulator to 0 when a sample with s_last=1 is accepted.
REQ-021 SHALL have latency of exactly 1 cycle from acceptance to m_valid when m_ready is held high, and sustain one sample per cycle.
REQ-022 SHALL use a one-entry output register plus one-entry skid buffer; s_ready = !skid_full, registered, not combinationally dependent on m_ready.
REQ-023 SHALL hold m_data and m_last stable while m_valid && !m_ready.
REQ-024 SHALL preserve sample order and never drop or duplicate a sample under any m_ready pattern.

Reset
REQ-025 SHALL on reset clear m_valid=0, skid empty, s_ready=1, accumulator=0, active and pending increment=0, FSM=IDLE.
REQ-026 SHALL discard a partially transferred packet on reset mid-packet; the next accepted sample after reset is treated as k=0.
REQ-027 SHALL leave m_data and m_last contents don't-care while m_valid=0.

Structure
REQ-028 SHALL take amp_t, arg_t, PI, PI_2 from the shared DSP package, also used by the downstream rotate stage.
REQ-029 SHALL instantiate the register-plus-skid handshake as one sub-module, skid_buffer, parameterised on data width.
REQ-030 SHALL keep accumulator, increment registers and FSM in phase_ramp itself.

Verification
REQ-031 SHALL verify: WIDTH=16, freq 0x20000000 in IDLE, 10-sample packet, m_ready=1 -> phases 0, 0x20000000, ..., 0xE0000000, 0, 0x20000000; i/q unchanged; m_last on 10th output only.
REQ-032 SHALL verify: inc=0xF0000000 (-pi/8), 3 samples -> phases 0, 0xF0000000, 0xE0000000.
REQ-033 SHALL verify: freq_valid 0x10000000 during sample 2 of a packet using 0x20000000 -> that packet continues at 0x20000000 steps; next packet steps by 0x10000000 starting at 0.
REQ-034 SHALL verify: continuous s_valid, m_ready toggling 1,0,0,1 pattern for 100 samples -> no loss/duplication, order preserved, m_data stable during stalls, s_ready never low with empty skid.
REQ-035 SHALL verify: reset asserted asynchronously after sample 4 of 8 -> m_valid=0 immediately, next packet starts at phase 0 with inc=0.
REQ-036 SHALL verify: back-to-back single-sample packets (s_last=1 every cycle) -> every output phase 0.
